// File: rtl/sqrt_job_queue_if.sv
// Stream, controller and result signals of the sqrt job queue.
// slave = queue side, master = environment side.
interface sqrt_job_queue_if #(
  parameter int NBITSIN = 32,
  parameter int DEPTH   = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                   in_valid;
  logic                   in_ready;
  logic [NBITSIN-1:0]     in_x;
  logic                   run;
  logic                   busy;
  logic [NBITSIN-1:0]     xin;
  logic [NBITSIN/2-1:0]   sqrt_in;
  logic                   out_valid;
  logic                   out_ready;
  logic [NBITSIN/2-1:0]   out_sqrt;
  logic [NBITSIN-1:0]     out_x;
  logic                   out_err;
  logic [CW-1:0]          pending;

  modport slave (
    input  in_valid, in_x, busy, sqrt_in, out_ready,
    output in_ready, run, xin, out_valid, out_sqrt, out_x, out_err, pending
  );

  modport master (
    output in_valid, in_x, busy, sqrt_in, out_ready,
    input  in_ready, run, xin, out_valid, out_sqrt, out_x, out_err, pending
  );
endinterface

// File: rtl/sqrt_job_queue.sv
// Operand FIFO + single-job issue engine in front of the sequential sqrt datapath.
// Optional result self-check (out_err) is built when SQRT_CHECK_EN is defined.
module sqrt_job_queue #(
  parameter int NBITSIN = 32,
  parameter int DEPTH   = 4
) (
  input  logic             clock,
  input  logic             reset,
  sqrt_job_queue_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int RW = NBITSIN / 2;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_ISSUE     = 3'd1;
  localparam logic [2:0] S_WAIT_BUSY = 3'd2;
  localparam logic [2:0] S_WAIT_DONE = 3'd3;
  localparam logic [2:0] S_SETTLE    = 3'd4;
  localparam logic [2:0] S_CAPTURE   = 3'd5;

  logic [NBITSIN-1:0] mem_q [DEPTH];
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic [2:0]         state_q, state_d;
  logic [NBITSIN-1:0] xin_q, xin_d;
  logic               out_valid_q, out_valid_d;
  logic [RW-1:0]      out_sqrt_q, out_sqrt_d;
  logic [NBITSIN-1:0] out_x_q, out_x_d;

  logic full, empty, push, pop, capture;

  // A full FIFO refuses the push even if a pop frees a slot this cycle.
  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign push    = bus.in_valid && !full;
  assign pop     = (state_q == S_IDLE) && !empty;
  assign capture = (state_q == S_CAPTURE) && (!out_valid_q || bus.out_ready);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    xin_d       = xin_q;
    out_valid_d = out_valid_q;
    out_sqrt_d  = out_sqrt_q;
    out_x_d     = out_x_q;
    count_d     = count_q + CW'(push) - CW'(pop);

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop) begin
      xin_d    = mem_q[rd_ptr_q];
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (out_valid_q && bus.out_ready) out_valid_d = 1'b0;

    case (state_q)
      S_IDLE:      if (!empty) state_d = S_ISSUE;
      S_ISSUE:     state_d = S_WAIT_BUSY;
      S_WAIT_BUSY: if (bus.busy) state_d = S_WAIT_DONE;
      S_WAIT_DONE: if (!bus.busy) state_d = S_SETTLE;
      S_SETTLE:    state_d = S_CAPTURE;
      S_CAPTURE: begin
        // Stalling here keeps sqrt_in held, since no new job can start.
        if (capture) begin
          out_valid_d = 1'b1;
          out_sqrt_d  = bus.sqrt_in;
          out_x_d     = xin_q;
          state_d     = S_IDLE;
        end
      end
      default:     state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      xin_q       <= '0;
      out_valid_q <= 1'b0;
      out_sqrt_q  <= '0;
      out_x_q     <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      xin_q       <= xin_d;
      out_valid_q <= out_valid_d;
      out_sqrt_q  <= out_sqrt_d;
      out_x_q     <= out_x_d;
    end
  end

  // NOTE: storage has no reset; resetting the pointers and count already makes its contents unreachable.
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= bus.in_x;
  end

`ifdef SQRT_CHECK_EN
  localparam int XW = NBITSIN + 1;

  logic [XW-1:0] root_ext, root_inc, x_ext, sq_lo, sq_hi;
  logic          chk_err;
  logic          out_err_q, out_err_d;

  // One spare bit keeps (s+1)^2 exact at the largest root.
  assign root_ext = {{(XW-RW){1'b0}}, bus.sqrt_in};
  assign root_inc = root_ext + XW'(1);
  assign x_ext    = {1'b0, xin_q};
  assign sq_lo    = root_ext * root_ext;
  assign sq_hi    = root_inc * root_inc;
  assign chk_err  = !((sq_lo <= x_ext) && (x_ext < sq_hi));

  always_comb begin
    out_err_d = out_err_q;
    if (capture) out_err_d = chk_err;
  end

  always_ff @(posedge clock) begin
    if (reset) out_err_q <= 1'b0;
    else       out_err_q <= out_err_d;
  end

  assign bus.out_err = out_err_q;
`else
  assign bus.out_err = 1'b0;
`endif

  assign bus.in_ready  = !full;
  assign bus.run       = (state_q == S_ISSUE);
  assign bus.xin       = xin_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sqrt  = out_sqrt_q;
  assign bus.out_x     = out_x_q;
  assign bus.pending   = count_q;
endmodule

// File: tb/tb_sqrt_job_queue.sv
// Self-checking bench for sqrt_job_queue with a behavioural sqrt controller model.
`timescale 1ns/1ps
module tb_sqrt_job_queue;
  localparam int NBITSIN = 32;
  localparam int DEPTH   = 4;
`ifdef SQRT_CHECK_EN
  localparam bit EXP_BAD_ERR = 1'b1;
`else
  localparam bit EXP_BAD_ERR = 1'b0;
`endif

  typedef struct {
    logic [31:0] x;
    logic [15:0] s;
    logic        err;
  } result_t;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  sqrt_job_queue_if #(.NBITSIN(NBITSIN), .DEPTH(DEPTH)) bus();
  sqrt_job_queue #(.NBITSIN(NBITSIN), .DEPTH(DEPTH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int passed = 0;
  int total  = 0;
  int run_count  = 0;
  int proto_errs = 0;
  bit bad_mode   = 1'b0;

  logic [31:0] acc_q[$];
  result_t     obs_q[$];

  // Integer square root, one result bit at a time from the top.
  function automatic logic [15:0] isqrt(input logic [31:0] x);
    longint r = 0;
    longint t;
    for (int b = 15; b >= 0; b--) begin
      t = r | (longint'(1) << b);
      if (t * t <= longint'(x)) r = t;
    end
    return r[15:0];
  endfunction

  function automatic logic [31:0] pick_operand();
    int unsigned k;
    case ($urandom_range(0, 3))
      0: return 32'($urandom_range(0, 300));
      1: return $urandom;
      2: begin k = $urandom_range(0, 65535); return 32'(k * k); end
      default: begin k = $urandom_range(1, 65535); return 32'(k * k - 1); end
    endcase
  endfunction

  // Controller + datapath model: busy rises 0..2 cycles after run, lasts 2..5 cycles.
  int          ctl_phase = 0;
  int          ctl_cnt   = 0;
  logic [31:0] ctl_x;
  always @(posedge clock) begin
    #2;
    if (reset) begin
      ctl_phase = 0;
      bus.busy = 1'b0;
      bus.sqrt_in = '0;
    end else if (bus.run) begin
      run_count++;
      if (ctl_phase != 0) proto_errs++;
      ctl_x = bus.xin;
      ctl_cnt = $urandom_range(0, 2);
      ctl_phase = 1;
    end else if (ctl_phase != 0) begin
      if (bus.xin !== ctl_x) proto_errs++;
      if (ctl_phase == 1) begin
        if (ctl_cnt == 0) begin
          bus.busy = 1'b1;
          ctl_cnt = $urandom_range(2, 5);
          ctl_phase = 2;
        end else ctl_cnt--;
      end else begin
        ctl_cnt--;
        if (ctl_cnt == 0) begin
          bus.busy = 1'b0;
          bus.sqrt_in = bad_mode ? 16'd4 : isqrt(ctl_x);
          ctl_phase = 0;
        end
      end
    end
  end

  // Records accepted operands and delivered results mid-cycle.
  always @(negedge clock) begin
    result_t r;
    if (reset) begin
      acc_q.delete();
      obs_q.delete();
    end else begin
      if (bus.in_valid && bus.in_ready) acc_q.push_back(bus.in_x);
      if (bus.out_valid && bus.out_ready) begin
        r.x = bus.out_x;
        r.s = bus.out_sqrt;
        r.err = bus.out_err;
        obs_q.push_back(r);
      end
    end
  end

  task automatic push(input logic [31:0] x);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_x = x;
    do begin
      @(negedge clock);
      n++;
    end while (!bus.in_ready && n < 200);
    @(posedge clock); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_results(input int n, input string name);
    int c = 0;
    while (obs_q.size() < n && c < 800) begin
      @(posedge clock); #1;
      c++;
    end
    total++;
    if (obs_q.size() < n) $display("FAIL %s timeout: got %0d results, need %0d", name, obs_q.size(), n);
    else passed++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_x = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    total++;
    if ({bus.in_ready, bus.run, bus.xin} !== {1'b1, 1'b0, 32'd0})
      $display("FAIL reset_in: in_ready/run/xin = %b/%b/%h, need 1/0/0", bus.in_ready, bus.run, bus.xin);
    else passed++;
    total++;
    if ({bus.out_valid, bus.out_sqrt, bus.out_x, bus.out_err} !== {1'b0, 16'd0, 32'd0, 1'b0})
      $display("FAIL reset_out: valid/sqrt/x/err = %b/%h/%h/%b, need 0/0/0/0", bus.out_valid, bus.out_sqrt, bus.out_x, bus.out_err);
    else passed++;
    total++;
    if (bus.pending !== 3'd0) $display("FAIL reset_pending: got %0d need 0", bus.pending);
    else passed++;
    @(posedge clock); #1;
  endtask

  task automatic test_directed();
    logic [31:0] xs[5] = '{32'd100, 32'd12, 32'd13, 32'd1057, 32'd4300};
    logic [15:0] ss[5] = '{16'd10, 16'd3, 16'd3, 16'd32, 16'd65};
    int r0 = run_count;
    result_t r;
    obs_q.delete();
    bus.out_ready = 1'b1;
    foreach (xs[i]) push(xs[i]);
    wait_results(5, "directed_drain");
    for (int i = 0; i < 5 && obs_q.size() > 0; i++) begin
      r = obs_q.pop_front();
      total++;
      if (r.x !== xs[i] || r.s !== ss[i] || r.err !== 1'b0)
        $display("FAIL directed[%0d]: x/s/err = %0d/%0d/%b, need %0d/%0d/0", i, r.x, r.s, r.err, xs[i], ss[i]);
      else passed++;
    end
    total++;
    if (run_count - r0 != 5) $display("FAIL directed_runs: got %0d run pulses, need 5", run_count - r0);
    else passed++;
  endtask

  task automatic test_boundary();
    logic [31:0] xs[2] = '{32'd0, 32'hFFFF_FFFF};
    logic [15:0] ss[2] = '{16'd0, 16'd65535};
    result_t r;
    obs_q.delete();
    bus.out_ready = 1'b1;
    foreach (xs[i]) push(xs[i]);
    wait_results(2, "boundary_drain");
    for (int i = 0; i < 2 && obs_q.size() > 0; i++) begin
      r = obs_q.pop_front();
      total++;
      if (r.x !== xs[i] || r.s !== ss[i] || r.err !== 1'b0)
        $display("FAIL boundary[%0d]: x/s/err = %h/%0d/%b, need %h/%0d/0", i, r.x, r.s, r.err, xs[i], ss[i]);
      else passed++;
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] ss[8] = '{16'd1, 16'd1, 16'd1, 16'd2, 16'd2, 16'd2, 16'd2, 16'd2};
    int idx = 0;
    int c = 0;
    result_t r;
    obs_q.delete();
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_x = 32'd1;
    repeat (60) begin
      @(negedge clock);
      if (bus.in_valid && bus.in_ready) idx++;
      @(posedge clock); #1;
      if (idx == 8) bus.in_valid = 1'b0;
      else bus.in_x = 32'(idx + 1);
    end
    @(negedge clock);
    total++;
    if (idx != 6) $display("FAIL b2b_accepts: got %0d, need 6", idx);
    else passed++;
    total++;
    if (bus.pending !== 3'd4 || bus.in_ready !== 1'b0)
      $display("FAIL b2b_full: pending/in_ready = %0d/%b, need 4/0", bus.pending, bus.in_ready);
    else passed++;
    @(posedge clock); #1;
    bus.out_ready = 1'b1;
    while (idx < 8 && c < 300) begin
      @(negedge clock);
      if (bus.in_valid && bus.in_ready) idx++;
      @(posedge clock); #1;
      if (idx == 8) bus.in_valid = 1'b0;
      else bus.in_x = 32'(idx + 1);
      c++;
    end
    bus.in_valid = 1'b0;
    total++;
    if (idx != 8) $display("FAIL b2b_resume: accepted %0d, need 8", idx);
    else passed++;
    wait_results(8, "b2b_drain");
    for (int i = 0; i < 8 && obs_q.size() > 0; i++) begin
      r = obs_q.pop_front();
      total++;
      if (r.x !== 32'(i + 1) || r.s !== ss[i])
        $display("FAIL b2b[%0d]: x/s = %0d/%0d, need %0d/%0d", i, r.x, r.s, i + 1, ss[i]);
      else passed++;
    end
  endtask

  task automatic test_reset_midflight();
    int c = 0;
    int r0;
    result_t r;
    obs_q.delete();
    bus.out_ready = 1'b1;
    push(32'd400); push(32'd900); push(32'd1600); push(32'd2500);
    do begin
      @(negedge clock);
      c++;
    end while (bus.busy !== 1'b1 && c < 100);
    total++;
    if (bus.busy !== 1'b1) $display("FAIL midreset_busy: busy=%b, need 1", bus.busy);
    else passed++;
    @(posedge clock); #1;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    r0 = run_count;
    @(negedge clock);
    total++;
    if ({bus.in_ready, bus.run, bus.xin, bus.out_valid, bus.out_sqrt, bus.out_x, bus.out_err, bus.pending}
        !== {1'b1, 1'b0, 32'd0, 1'b0, 16'd0, 32'd0, 1'b0, 3'd0})
      $display("FAIL midreset_vals: in_ready=%b run=%b xin=%h ov=%b s=%h x=%h err=%b pend=%0d, need 1/0/0/0/0/0/0/0",
               bus.in_ready, bus.run, bus.xin, bus.out_valid, bus.out_sqrt, bus.out_x, bus.out_err, bus.pending);
    else passed++;
    repeat (40) @(posedge clock);
    #1;
    total++;
    if (obs_q.size() != 0 || run_count != r0)
      $display("FAIL midreset_flush: results=%0d runs=%0d, need 0/0", obs_q.size(), run_count - r0);
    else passed++;
    push(32'd49);
    wait_results(1, "midreset_drain");
    if (obs_q.size() > 0) begin
      r = obs_q.pop_front();
      total++;
      if (r.x !== 32'd49 || r.s !== 16'd7) $display("FAIL midreset_49: x/s = %0d/%0d, need 49/7", r.x, r.s);
      else passed++;
    end
  endtask

  task automatic test_err_inject();
    result_t r;
    obs_q.delete();
    bus.out_ready = 1'b1;
    bad_mode = 1'b1;
    push(32'd100);
    wait_results(1, "err_drain");
    bad_mode = 1'b0;
    if (obs_q.size() > 0) begin
      r = obs_q.pop_front();
      total++;
      if (r.x !== 32'd100 || r.s !== 16'd4 || r.err !== EXP_BAD_ERR)
        $display("FAIL err_inject: x/s/err = %0d/%0d/%b, need 100/4/%b", r.x, r.s, r.err, EXP_BAD_ERR);
      else passed++;
    end
  endtask

  task automatic test_random();
    int n_sent = 0;
    int cyc = 0;
    int r0 = run_count;
    bit acc;
    result_t r;
    logic [31:0] x;
    acc_q.delete();
    obs_q.delete();
    bus.in_valid = 1'b0;
    while (n_sent < 25 && cyc < 3000) begin
      @(negedge clock);
      acc = bus.in_valid && bus.in_ready;
      if (acc) n_sent++;
      @(posedge clock); #1;
      bus.out_ready = ($urandom_range(0, 3) != 0);
      if (acc || !bus.in_valid) begin
        if (n_sent < 25 && $urandom_range(0, 2) != 0) begin
          bus.in_valid = 1'b1;
          bus.in_x = pick_operand();
        end else bus.in_valid = 1'b0;
      end
      cyc++;
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    wait_results(25, "random_drain");
    for (int i = 0; i < 25 && obs_q.size() > 0 && acc_q.size() > 0; i++) begin
      r = obs_q.pop_front();
      x = acc_q.pop_front();
      total++;
      if (r.x !== x || r.s !== isqrt(x) || r.err !== 1'b0)
        $display("FAIL random[%0d]: x/s/err = %h/%0d/%b, need %h/%0d/0", i, r.x, r.s, r.err, x, isqrt(x));
      else passed++;
    end
    total++;
    if (run_count - r0 != 25) $display("FAIL random_runs: got %0d run pulses, need 25", run_count - r0);
    else passed++;
  endtask

  task automatic test_protocol();
    total++;
    if (proto_errs != 0) $display("FAIL protocol: %0d run-overlap/xin-stability violations, need 0", proto_errs);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_boundary();
    test_back_to_back();
    test_reset_midflight();
    test_err_inject();
    test_random();
    test_protocol();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
